// File: rtl/uart_tx_cfg_if.sv
// Valid/ready transmit port of the configurable UART transmitter.
// The sender (master) drives the byte and its valid flag. The transmitter
// (slave) returns ready, the serial line and the frame status flags.
interface uart_tx_cfg_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 tx_valid;
    logic                 tx_ready;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx;
    logic                 busy;
    logic                 frame_done;

    modport master (
        output tx_valid,
        output tx_data,
        input  tx_ready,
        input  tx,
        input  busy,
        input  frame_done
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        output tx_ready,
        output tx,
        output busy,
        output frame_done
    );
endinterface

// File: rtl/uart_tx_cfg.sv
// UART transmitter with an integrated baud divider.
// The frame format (5-9 data bits, none/odd/even parity, 1-2 stop bits) is
// fixed at elaboration. Data is sent LSB first. Every output is a flop.
// The next-state logic computes the value each output will hold once the
// state changes, so every output changes on the same edge as the state.
module uart_tx_cfg #(
    parameter int unsigned CLK_FREQ  = 100_000_000,
    parameter int unsigned BAUD      = 9600,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    uart_tx_cfg_if.slave bus
);
    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

    // Elaboration-time legality checks on the frame format and divider.
    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_cpb
            $error("uart_tx_cfg: CLK_FREQ/BAUD must be at least 2");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
            $error("uart_tx_cfg: DATA_BITS must be 5..9");
        end
        if (PARITY > 2) begin : g_bad_par
            $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
            $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // The parity bit for a payload: even -> XOR of the bits, odd -> XNOR.
    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        logic p;
        p = ^d;
        if (PARITY == 32'd2) begin
            parity_of = p;
        end else if (PARITY == 32'd1) begin
            parity_of = ~p;
        end else begin
            parity_of = 1'b0;
        end
    endfunction

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 ready_q, ready_d;
    logic                 done_q, done_d;
    logic                 accept_s;
    logic                 bit_end_s;

    assign accept_s  = bus.tx_valid && ready_q;
    assign bit_end_s = (cnt_q == CNT_LAST);

    // Next-state logic and next values of the registered outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        tx_d    = 1'b1;
        busy_d  = 1'b1;
        ready_d = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy_d  = 1'b0;
                ready_d = 1'b1;
                if (accept_s) begin
                    state_d = S_START;
                    cnt_d   = '0;
                    bit_d   = 4'd0;
                    shreg_d = bus.tx_data;
                    par_d   = parity_of(bus.tx_data);
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                tx_d = 1'b0;
                if (bit_end_s) begin
                    cnt_d   = '0;
                    bit_d   = 4'd0;
                    state_d = S_DATA;
                    tx_d    = shreg_q[0];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                tx_d = shreg_q[0];
                if (bit_end_s) begin
                    cnt_d   = '0;
                    shreg_d = {1'b0, shreg_q[DATA_BITS-1:1]};
                    if (bit_q == DATA_LAST) begin
                        bit_d = 4'd0;
                        if (PARITY != 32'd0) begin
                            state_d = S_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                        tx_d  = shreg_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PARITY: begin
                tx_d = par_q;
                if (bit_end_s) begin
                    cnt_d   = '0;
                    bit_d   = 4'd0;
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                tx_d = 1'b1;
                if (bit_end_s) begin
                    cnt_d = '0;
                    if (bit_q == STOP_LAST) begin
                        // Last stop cycle: land in IDLE already announcing completion.
                        bit_d   = 4'd0;
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        ready_d = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                bit_d   = 4'd0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, counters, payload and output flops; reset abandons any frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= 4'd0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign bus.tx         = tx_q;
    assign bus.busy       = busy_q;
    assign bus.tx_ready   = ready_q;
    assign bus.frame_done = done_q;
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Testbench for uart_tx_cfg. Four instances run at 10 clocks per bit with
// formats 8N1, 8E1, 8O1 and 7O2. One instance is active at a time.
// Expected line waveforms come from fixed frame vectors or from a frame model
// built from the format rules.
module tb_uart_tx_cfg;
    localparam int CPB = 10;

    logic clk = 1'b0;
    logic rst_n;
    int   sel;
    logic vld;
    logic [8:0] dat;
    int   n_cmp = 0;
    int   n_err = 0;
    int   hs_cnt = 0;
    int   done_cnt = 0;
    logic m_tx, m_busy, m_ready, m_done;

    uart_tx_cfg_if #(.DATA_BITS(8)) if0 ();
    uart_tx_cfg_if #(.DATA_BITS(8)) if1 ();
    uart_tx_cfg_if #(.DATA_BITS(8)) if2 ();
    uart_tx_cfg_if #(.DATA_BITS(7)) if3 ();

    uart_tx_cfg #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
        u_8n1 (.clk(clk), .rst_n(rst_n), .bus(if0));
    uart_tx_cfg #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1))
        u_8e1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    uart_tx_cfg #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1))
        u_8o1 (.clk(clk), .rst_n(rst_n), .bus(if2));
    uart_tx_cfg #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2))
        u_7o2 (.clk(clk), .rst_n(rst_n), .bus(if3));

    assign if0.tx_valid = vld && (sel == 0);
    assign if1.tx_valid = vld && (sel == 1);
    assign if2.tx_valid = vld && (sel == 2);
    assign if3.tx_valid = vld && (sel == 3);
    assign if0.tx_data  = dat[7:0];
    assign if1.tx_data  = dat[7:0];
    assign if2.tx_data  = dat[7:0];
    assign if3.tx_data  = dat[6:0];

    always #5 clk = ~clk;

    // Route the selected instance's outputs to the common check signals.
    always_comb begin
        m_tx = 1'b1; m_busy = 1'b0; m_ready = 1'b0; m_done = 1'b0;
        case (sel)
            0: begin m_tx = if0.tx; m_busy = if0.busy; m_ready = if0.tx_ready; m_done = if0.frame_done; end
            1: begin m_tx = if1.tx; m_busy = if1.busy; m_ready = if1.tx_ready; m_done = if1.frame_done; end
            2: begin m_tx = if2.tx; m_busy = if2.busy; m_ready = if2.tx_ready; m_done = if2.frame_done; end
            3: begin m_tx = if3.tx; m_busy = if3.busy; m_ready = if3.tx_ready; m_done = if3.frame_done; end
            default: begin m_tx = 1'b1; end
        endcase
    end

    // Count handshakes and completion pulses on the selected instance.
    always @(posedge clk) begin
        if (vld && m_ready) hs_cnt <= hs_cnt + 1;
        if (m_done) done_cnt <= done_cnt + 1;
    end

    typedef struct {
        int         sel;
        logic [8:0] data;
        logic [12:0] frame;
        int         nbits;
        string      name;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame model: line bit i of the frame, built from the format rules.
    function automatic void model_frame(input int s, input logic [8:0] d,
                                        output logic [12:0] f, output int n);
        int db, par, sb, ones;
        case (s)
            0: begin db = 8; par = 0; sb = 1; end
            1: begin db = 8; par = 2; sb = 1; end
            2: begin db = 8; par = 1; sb = 1; end
            default: begin db = 7; par = 1; sb = 2; end
        endcase
        f = '1;
        n = 0;
        ones = 0;
        f[n] = 1'b0; n++;
        for (int i = 0; i < db; i++) begin
            f[n] = d[i];
            ones += int'(d[i]);
            n++;
        end
        if (par != 0) begin
            if (par == 2) f[n] = ((ones % 2) == 1);
            else          f[n] = ((ones % 2) == 0);
            n++;
        end
        for (int i = 0; i < sb; i++) begin
            f[n] = 1'b1; n++;
        end
    endfunction

    // Wait (bounded) for ready, present a byte, and stop at the negedge after the accept edge.
    task automatic start_frame(input int s, input logic [8:0] d, input bit hold);
        int t;
        sel = s;
        t = 0;
        while (!m_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!m_ready) chk("ready_wait_timeout", 32'd0, 32'd1);
        vld = 1'b1;
        dat = d;
        @(posedge clk);
        @(negedge clk);
        if (!hold) vld = 1'b0;
    endtask

    // Check {tx,busy,ready,done} every cycle of a frame and on its completion cycle.
    task automatic run_frame(input string nm, input logic [12:0] f, input int n,
                             input int poke_k, input logic [8:0] poke_d, input int pulse_k);
        for (int k = 0; k <= n * CPB; k++) begin
            logic [3:0] e;
            if (k < n * CPB) e = {f[k / CPB], 1'b1, 1'b0, 1'b0};
            else             e = 4'b1011;
            chk($sformatf("%s k=%0d {tx,busy,rdy,done}", nm, k),
                {28'd0, m_tx, m_busy, m_ready, m_done}, {28'd0, e});
            if (k == poke_k) dat = poke_d;
            if (pulse_k >= 0 && k == pulse_k) vld = 1'b1;
            if (pulse_k >= 0 && k == pulse_k + 1) vld = 1'b0;
            if (k < n * CPB) @(negedge clk);
        end
    endtask

    // Global watchdog.
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[4];
        logic [12:0] f;
        int n, hs0, dn0;
        logic [8:0] d;
        int s;

        vt[0] = '{0, 9'h0A5, {3'b000, 1'b1, 8'hA5, 1'b0}, 10, "8N1_A5"};
        vt[1] = '{1, 9'h0A5, {2'b00, 1'b1, 1'b0, 8'hA5, 1'b0}, 11, "8E1_A5"};
        vt[2] = '{2, 9'h0A5, {2'b00, 1'b1, 1'b1, 8'hA5, 1'b0}, 11, "8O1_A5"};
        vt[3] = '{3, 9'h041, {2'b00, 2'b11, 1'b1, 7'h41, 1'b0}, 11, "7O2_41"};

        rst_n = 1'b0; vld = 1'b0; sel = 0; dat = 9'd0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            sel = i;
            #1;
            chk($sformatf("reset dut%0d {tx,busy,rdy,done}", i),
                {28'd0, m_tx, m_busy, m_ready, m_done}, {28'd0, 4'b1000});
        end
        sel = 0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready after reset release", {31'd0, m_ready}, 32'd1);

        // Fixed frame vectors.
        for (int i = 0; i < 4; i++) begin
            start_frame(vt[i].sel, vt[i].data, 1'b0);
            run_frame(vt[i].name, vt[i].frame, vt[i].nbits, -1, 9'd0, -1);
        end

        // Back-to-back 8N1 frames with valid held high.
        hs0 = hs_cnt; dn0 = done_cnt;
        start_frame(0, 9'h000, 1'b1);
        dat = 9'h0FF;
        run_frame("b2b_00", {3'b000, 1'b1, 8'h00, 1'b0}, 10, -1, 9'd0, -1);
        @(negedge clk);
        vld = 1'b0;
        run_frame("b2b_FF", {3'b000, 1'b1, 8'hFF, 1'b0}, 10, -1, 9'd0, -1);
        @(negedge clk);
        chk("b2b handshakes", hs_cnt - hs0, 32'd2);
        chk("b2b frame_done pulses", done_cnt - dn0, 32'd2);

        // Data change mid-frame and a valid pulse while busy.
        hs0 = hs_cnt;
        start_frame(0, 9'h0A5, 1'b0);
        run_frame("stable_A5", {3'b000, 1'b1, 8'hA5, 1'b0}, 10, 20, 9'h0FF, 30);
        @(negedge clk);
        chk("busy-pulse handshakes", hs_cnt - hs0, 32'd1);

        // Reset in the middle of data bit 2.
        dn0 = done_cnt;
        start_frame(0, 9'h0A5, 1'b0);
        repeat (35) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid-frame reset {tx,busy,rdy,done}",
            {28'd0, m_tx, m_busy, m_ready, m_done}, {28'd0, 4'b1000});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready after mid-frame reset", {31'd0, m_ready}, 32'd1);
        chk("no frame_done after reset", done_cnt - dn0, 32'd0);
        model_frame(0, 9'h03C, f, n);
        start_frame(0, 9'h03C, 1'b0);
        run_frame("post_reset_3C", f, n, -1, 9'd0, -1);

        // Randomised frames against the frame model.
        for (int r = 0; r < 12; r++) begin
            s = int'($urandom_range(0, 3));
            d = 9'($urandom) & 9'h0FF;
            model_frame(s, d, f, n);
            @(negedge clk);
            start_frame(s, d, 1'b0);
            run_frame($sformatf("rand%0d_dut%0d_%0h", r, s, d), f, n, -1, 9'd0, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
